snake_game_ctrl: RTL and testbench
==================================

// Module: snake_game_ctrl
// PURPOSE
//  Game sequencer in the vga_clk domain, placed between the button/start inputs and vga_display.
//  Owns snake body, direction, food position, score and game FSM; advances the snake once per move tick.
//  vga_display reads board occupancy through a registered per-cell query port.
// PARAMETERS
//  GRID_W   40         board width in cells (<=64); cell x is 6 bits
//  GRID_H   30         board height in cells (<=32); cell y is 5 bits
//  MAX_LEN  32         max segments; body held in MAX_LEN-entry shift register
//  TICK_DIV 5_000_000  vga_clk cycles per move (5 moves/s at 25 MHz); >=4
// PORTS
//  vga_clk    in   1  25 MHz pixel clock, sole clock
//  sys_rst_n  in   1  asynchronous active-low reset
//  direct_x   in   4  direction request, active-high: [0]up [1]down [2]left [3]right
//  sta_en     in   1  start/restart level; its rising edge is the event
//  q_x        in   6  query cell x (from pixel_xpos/16)
//  q_y        in   5  query cell y (from pixel_ypos/16)
//  q_body     out  1  queried cell holds a body segment (incl. head), 1-cycle latency
//  q_head     out  1  queried cell is the head, 1-cycle latency
//  q_food     out  1  queried cell is food, 1-cycle latency
//  game_st    out  2  0 IDLE, 1 RUN, 2 FOOD, 3 DEAD
//  score      out  8  foods eaten, saturates at 255
//  snake_len  out  6  current length, 3..MAX_LEN
//  move_pulse out  1  one-cycle pulse on each applied move
// BEHAVIOUR
//  Reset: game_st=IDLE, score=0, snake_len=3, seg0..2=(20,15),(19,15),(18,15), dir=right,
//   food=(30,15), LFSR=16'hACE1, tick counter=0, q_*=0, move_pulse=0, sta_en edge register=0.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle in every state.
//  Direction: each cycle, a nonzero direct_x is latched into pend_dir, priority up>down>left>right.
//   At a tick, pend_dir is applied unless it is the reverse of the current dir, in which case it is ignored.
//  IDLE: board held at its init values. sta_en rising edge -> RUN with tick counter cleared.
//  RUN: tick counter counts 0..TICK_DIV-1. At terminal count:
//   - apply dir, then compute nxt = head + dir.
//   - wall: nxt outside 0..GRID_W-1 / 0..GRID_H-1 -> DEAD, body unchanged.
//   - eat = (nxt == food).
//   - self: nxt equals any seg i < snake_len-1 (no eat) or i < snake_len (eat) -> DEAD.
//   - else shift body (seg[i+1]<=seg[i], seg0<=nxt) and assert move_pulse for 1 cycle.
//   - on eat: snake_len+1 (saturates at MAX_LEN; at MAX_LEN the tail still drops),
//     score+1 (saturating), next state FOOD.
//  FOOD: each cycle candidate cx=lfsr[5:0], cy=lfsr[10:6]. Accept only if cx<GRID_W, cy<GRID_H,
//   and the cell is not occupied by the snake; on accept: food<=cand, state -> RUN.
//   Otherwise retry next cycle. The tick counter keeps running in FOOD.
//   A tick that lands in FOOD is deferred, not dropped, and is applied on the RUN entry cycle.
//  DEAD: board frozen, score held. sta_en rising edge -> IDLE; all reset values are restored
//   except LFSR and food, and score clears to 0.
//  sta_en edges in RUN/FOOD are ignored. sta_en held high does not retrigger (edge-detected only).
//  Query: q_x/q_y are registered; outputs are valid the cycle after the address,
//   computed by a parallel compare over seg[0..snake_len-1]. An out-of-grid query returns 0.
//  Reset mid-game: immediate asynchronous return to the reset state; no partial move is visible.
// CONFIGURATION
//  SNAKE_WRAP_EN defined: walls wrap instead of killing (x -1 -> GRID_W-1, GRID_W -> 0; same for y).
//   Only self-collision causes DEAD.
//  SNAKE_WRAP_EN undefined: a wall hit -> DEAD as described above.
// TESTING (TICK_DIV=4 for sim)
//  1. Reset, pulse sta_en, no buttons -> game_st=1; head (21,15) after 1st move_pulse, (22,15) after 2nd; len=3.
//  2. In RUN press left (reverse of right), then up -> left ignored; next move head (x,14) from (x,15).
//  3. Force food=(21,15) and start -> at 1st move len=4, score=1, game_st=2 then 1;
//     new food lies in-grid and off the body.
//  4. Steer up from y=15 for 16 moves -> 16th computes y=-1; game_st=3 and head stays (x,0).
//     With SNAKE_WRAP_EN, head becomes (x,29) and game_st stays 1.
//  5. Grow to len 5, then issue up, left, down in turn -> self hit -> DEAD.
//     sta_en edge -> IDLE, score=0, len=3; a second edge -> RUN.
//  6. Query q=(20,15) in IDLE -> next cycle q_head=1, q_body=1; q=(30,15) -> q_food=1;
//     q=(63,31) -> all 0. Assert sys_rst_n low mid-RUN -> all reset values immediately.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: snake game sequencer in the pixel clock domain. Owns body,
// direction, food, score and game FSM, and answers registered per-cell queries.
// Optional build macro SNAKE_WRAP_EN: walls wrap around instead of killing.
module snake_game_ctrl #(
  parameter int unsigned GRID_W   = 40,
  parameter int unsigned GRID_H   = 30,
  parameter int unsigned MAX_LEN  = 32,
  parameter int unsigned TICK_DIV = 5_000_000
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] direct_x,
  input  logic       sta_en,
  input  logic [5:0] q_x,
  input  logic [4:0] q_y,
  output logic       q_body,
  output logic       q_head,
  output logic       q_food,
  output logic [1:0] game_st,
  output logic [7:0] score,
  output logic [5:0] snake_len,
  output logic       move_pulse
);
  localparam int unsigned XW = 6;
  localparam int unsigned YW = 5;
  localparam int unsigned LW = 6;
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FOOD = 2'd2, ST_DEAD = 2'd3} state_e;
  // Opposite directions differ only in bit 0.
  typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_e;

  state_e        state_q, state_d;
  logic [XW-1:0] seg_x_q [MAX_LEN];
  logic [XW-1:0] seg_x_d [MAX_LEN];
  logic [YW-1:0] seg_y_q [MAX_LEN];
  logic [YW-1:0] seg_y_d [MAX_LEN];
  logic [LW-1:0] len_q, len_d;
  dir_e          dir_q, dir_d, pend_q, pend_d, new_dir;
  logic [XW-1:0] food_x_q, food_x_d;
  logic [YW-1:0] food_y_q, food_y_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    score_q, score_d;
  logic          sta_q, defer_q, defer_d, move_q, move_d;
  logic          qb_q, qh_q, qf_q, qb_d, qh_d, qf_d;

  logic          sta_rise, term, wall, eat, self_hit, die, cand_hit, cand_ok, q_in;
  logic [XW-1:0] nx, cx;
  logic [YW-1:0] ny, cy;

  function automatic logic [XW-1:0] init_x(input int unsigned i);
    return (i < 3) ? XW'(20 - i) : '0;
  endfunction

  function automatic logic [YW-1:0] init_y(input int unsigned i);
    return (i < 3) ? YW'(15) : '0;
  endfunction

  assign sta_rise = sta_en & ~sta_q;
  assign term     = (cnt_q == CW'(TICK_DIV - 1));

`ifdef SNAKE_WRAP_EN
  assign die = self_hit;
`else
  assign die = wall | self_hit;
`endif

  // Direction arbitration and next head cell (wrapped coordinates plus wall flag)
  always_comb begin
    new_dir = ((pend_q ^ dir_q) == 2'b01) ? dir_q : pend_q;
    nx      = seg_x_q[0];
    ny      = seg_y_q[0];
    wall    = 1'b0;
    case (new_dir)
      DIR_UP: begin
        if (seg_y_q[0] == '0) begin wall = 1'b1; ny = YW'(GRID_H - 1); end
        else ny = seg_y_q[0] - YW'(1);
      end
      DIR_DOWN: begin
        if (seg_y_q[0] == YW'(GRID_H - 1)) begin wall = 1'b1; ny = '0; end
        else ny = seg_y_q[0] + YW'(1);
      end
      DIR_LEFT: begin
        if (seg_x_q[0] == '0) begin wall = 1'b1; nx = XW'(GRID_W - 1); end
        else nx = seg_x_q[0] - XW'(1);
      end
      default: begin
        if (seg_x_q[0] == XW'(GRID_W - 1)) begin wall = 1'b1; nx = '0; end
        else nx = seg_x_q[0] + XW'(1);
      end
    endcase
  end

  // Parallel body compares: self collision, food candidate and display query
  always_comb begin
    eat      = (nx == food_x_q) && (ny == food_y_q);
    cx       = lfsr_q[5:0];
    cy       = lfsr_q[10:6];
    q_in     = ({1'b0, q_x} < 7'(GRID_W)) && ({1'b0, q_y} < 6'(GRID_H));
    self_hit = 1'b0;
    cand_hit = 1'b0;
    qb_d     = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < len_q) begin
        // Without eating, the tail cell is vacated by this same move.
        if (seg_x_q[i] == nx && seg_y_q[i] == ny && (eat || LW'(i) < len_q - LW'(1)))
          self_hit = 1'b1;
        if (seg_x_q[i] == cx && seg_y_q[i] == cy)
          cand_hit = 1'b1;
        if (q_in && seg_x_q[i] == q_x && seg_y_q[i] == q_y)
          qb_d = 1'b1;
      end
    end
    qh_d    = q_in && (seg_x_q[0] == q_x) && (seg_y_q[0] == q_y);
    qf_d    = q_in && (food_x_q == q_x) && (food_y_q == q_y);
    cand_ok = ({1'b0, cx} < 7'(GRID_W)) && ({1'b0, cy} < 6'(GRID_H)) && !cand_hit;
  end

  // Game FSM: next state, body update, food placement, score and move pulse
  always_comb begin
    state_d  = state_q;
    seg_x_d  = seg_x_q;
    seg_y_d  = seg_y_q;
    len_d    = len_q;
    dir_d    = dir_q;
    pend_d   = pend_q;
    food_x_d = food_x_q;
    food_y_d = food_y_q;
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    cnt_d    = term ? '0 : cnt_q + CW'(1);
    score_d  = score_q;
    defer_d  = defer_q;
    move_d   = 1'b0;

    if (direct_x[0])      pend_d = DIR_UP;
    else if (direct_x[1]) pend_d = DIR_DOWN;
    else if (direct_x[2]) pend_d = DIR_LEFT;
    else if (direct_x[3]) pend_d = DIR_RIGHT;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (sta_rise) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (term || defer_q) begin
          defer_d = 1'b0;
          dir_d   = new_dir;
          if (die) begin
            state_d = ST_DEAD;
          end else begin
            for (int unsigned i = 1; i < MAX_LEN; i++) begin
              seg_x_d[i] = seg_x_q[i-1];
              seg_y_d[i] = seg_y_q[i-1];
            end
            seg_x_d[0] = nx;
            seg_y_d[0] = ny;
            move_d     = 1'b1;
            if (eat) begin
              if (len_q != LW'(MAX_LEN)) len_d = len_q + LW'(1);
              if (score_q != 8'hFF)      score_d = score_q + 8'd1;
              state_d = ST_FOOD;
            end
          end
        end
      end
      ST_FOOD: begin
        // A move due while placing food is held and taken on RUN entry.
        if (term) defer_d = 1'b1;
        if (cand_ok) begin
          food_x_d = cx;
          food_y_d = cy;
          state_d  = ST_RUN;
        end
      end
      default: begin
        cnt_d   = '0;
        defer_d = 1'b0;
        if (sta_rise) begin
          state_d = ST_IDLE;
          len_d   = LW'(3);
          dir_d   = DIR_RIGHT;
          pend_d  = DIR_RIGHT;
          score_d = '0;
          for (int unsigned i = 0; i < MAX_LEN; i++) begin
            seg_x_d[i] = init_x(i);
            seg_y_d[i] = init_y(i);
          end
        end
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= init_x(i);
        seg_y_q[i] <= init_y(i);
      end
      len_q    <= LW'(3);
      dir_q    <= DIR_RIGHT;
      pend_q   <= DIR_RIGHT;
      food_x_q <= XW'(30);
      food_y_q <= YW'(15);
      lfsr_q   <= 16'hACE1;
      cnt_q    <= '0;
      score_q  <= '0;
      sta_q    <= 1'b0;
      defer_q  <= 1'b0;
      move_q   <= 1'b0;
      qb_q     <= 1'b0;
      qh_q     <= 1'b0;
      qf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      seg_x_q  <= seg_x_d;
      seg_y_q  <= seg_y_d;
      len_q    <= len_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      food_x_q <= food_x_d;
      food_y_q <= food_y_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      score_q  <= score_d;
      sta_q    <= sta_en;
      defer_q  <= defer_d;
      move_q   <= move_d;
      qb_q     <= qb_d;
      qh_q     <= qh_d;
      qf_q     <= qf_d;
    end
  end

  assign game_st    = state_q;
  assign score      = score_q;
  assign snake_len  = len_q;
  assign move_pulse = move_q;
  assign q_body     = qb_q;
  assign q_head     = qh_q;
  assign q_food     = qf_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: random game play against a queue-based reference model;
// expected per-cycle outputs go through a scoreboard queue to a separate monitor.
module tb_snake_game_ctrl;
  localparam int GW = 40;
  localparam int GH = 30;
  localparam int ML = 32;
  localparam int TD = 4;
`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] direct_x;
  logic       sta_en;
  logic [5:0] q_x;
  logic [4:0] q_y;
  logic       q_body, q_head, q_food, move_pulse;
  logic [1:0] game_st;
  logic [7:0] score;
  logic [5:0] snake_len;

  always #5 clk = ~clk;

  snake_game_ctrl #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .TICK_DIV(TD)) dut (
    .vga_clk(clk), .sys_rst_n(rst_n), .direct_x(direct_x), .sta_en(sta_en),
    .q_x(q_x), .q_y(q_y), .q_body(q_body), .q_head(q_head), .q_food(q_food),
    .game_st(game_st), .score(score), .snake_len(snake_len), .move_pulse(move_pulse)
  );

  typedef struct {int x; int y;} cell_t;
  typedef struct {int st; int sc; int ln; bit mv; bit qb; bit qh; bit qf;} exp_t;

  // Reference model state: body as a queue, head at index 0.
  cell_t body[$];
  exp_t  exp_q[$];
  exp_t  mon_e;
  int    m_st, m_sc, m_cnt, m_lfsr, m_dx, m_dy, m_px, m_py, m_fx, m_fy;
  bit    m_defer, m_sprev;
  int    vectors = 0;
  int    errors = 0;
  bit    rand_q = 1'b0;

  function automatic int lfsr_next(input int l);
    return ((l << 1) | (((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1)) & 'hFFFF;
  endfunction

  task automatic model_init(input bit full);
    cell_t c;
    body.delete();
    for (int i = 0; i < 3; i++) begin c.x = 20 - i; c.y = 15; body.push_back(c); end
    m_st = 0; m_sc = 0; m_cnt = 0; m_defer = 1'b0;
    m_dx = 1; m_dy = 0; m_px = 1; m_py = 0;
    if (full) begin m_lfsr = 'hACE1; m_fx = 30; m_fy = 15; m_sprev = 1'b0; end
  endtask

  function automatic bit on_body(input int x, input int y, input int n);
    for (int i = 0; i < n; i++) if (body[i].x == x && body[i].y == y) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    exp_t  e;
    cell_t c;
    bit    rise, ing, restore, tick, wall, eat, hit;
    int    npx, npy, nx, ny, cx, cy, lim, qx, qy;
    qx   = int'(q_x);
    qy   = int'(q_y);
    rise = sta_en && !m_sprev;
    ing  = (qx < GW) && (qy < GH);
    e.qh = ing && body[0].x == qx && body[0].y == qy;
    e.qb = ing && on_body(qx, qy, body.size());
    e.qf = ing && m_fx == qx && m_fy == qy;
    e.mv = 1'b0;
    restore = 1'b0;
    npx = m_px; npy = m_py;
    if (direct_x[0])      begin npx = 0;  npy = -1; end
    else if (direct_x[1]) begin npx = 0;  npy = 1;  end
    else if (direct_x[2]) begin npx = -1; npy = 0;  end
    else if (direct_x[3]) begin npx = 1;  npy = 0;  end
    case (m_st)
      0: if (rise) begin m_st = 1; m_cnt = 0; end
      1: begin
        tick  = (m_cnt == TD - 1) || m_defer;
        m_cnt = (m_cnt == TD - 1) ? 0 : m_cnt + 1;
        if (tick) begin
          m_defer = 1'b0;
          if (!(m_px == -m_dx && m_py == -m_dy)) begin m_dx = m_px; m_dy = m_py; end
          nx   = body[0].x + m_dx;
          ny   = body[0].y + m_dy;
          wall = nx < 0 || nx >= GW || ny < 0 || ny >= GH;
          nx   = (nx + GW) % GW;
          ny   = (ny + GH) % GH;
          eat  = nx == m_fx && ny == m_fy;
          lim  = eat ? body.size() : body.size() - 1;
          hit  = on_body(nx, ny, lim);
          if ((wall && !WRAP) || hit) begin
            m_st = 3;
          end else begin
            c.x = nx; c.y = ny;
            body.push_front(c);
            if (!eat || body.size() > ML) void'(body.pop_back());
            e.mv = 1'b1;
            if (eat) begin
              if (m_sc < 255) m_sc++;
              m_st = 2;
            end
          end
        end
      end
      2: begin
        if (m_cnt == TD - 1) m_defer = 1'b1;
        m_cnt = (m_cnt == TD - 1) ? 0 : m_cnt + 1;
        cx = m_lfsr & 63;
        cy = (m_lfsr >> 6) & 31;
        if (cx < GW && cy < GH && !on_body(cx, cy, body.size())) begin
          m_fx = cx; m_fy = cy; m_st = 1;
        end
      end
      default: if (rise) restore = 1'b1;
    endcase
    m_px = npx; m_py = npy;
    if (restore) model_init(1'b0);
    m_lfsr  = lfsr_next(m_lfsr);
    m_sprev = sta_en;
    e.st = m_st; e.sc = m_sc; e.ln = body.size();
    exp_q.push_back(e);
  endtask

  // Reference model: advances with the DUT and pushes the expected post-edge outputs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_init(1'b1);
      exp_q.delete();
    end else begin
      model_step();
    end
  end

  // Monitor: compares DUT outputs against the oldest scoreboard entry
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      vectors++;
      if (int'(game_st) != mon_e.st || int'(score) != mon_e.sc || int'(snake_len) != mon_e.ln ||
          move_pulse != mon_e.mv || q_body != mon_e.qb || q_head != mon_e.qh || q_food != mon_e.qf) begin
        errors++;
        $display("FAIL cycle t=%0t: got st=%0d sc=%0d len=%0d mv=%0d qb/qh/qf=%0d%0d%0d, want st=%0d sc=%0d len=%0d mv=%0d qb/qh/qf=%0d%0d%0d",
                 $time, game_st, score, snake_len, move_pulse, q_body, q_head, q_food,
                 mon_e.st, mon_e.sc, mon_e.ln, mon_e.mv, mon_e.qb, mon_e.qh, mon_e.qf);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    vectors++;
    if (game_st !== 2'd0 || score !== 8'd0 || snake_len !== 6'd3 || move_pulse !== 1'b0 ||
        q_body !== 1'b0 || q_head !== 1'b0 || q_food !== 1'b0) begin
      errors++;
      $display("FAIL %s: got st=%0d sc=%0d len=%0d mv=%0d q=%0d%0d%0d, want st=0 sc=0 len=3 mv=0 q=000",
               tag, game_st, score, snake_len, move_pulse, q_body, q_head, q_food);
    end
  endtask

  task automatic pick_query();
    int r, k;
    r = $urandom_range(0, 3);
    case (r)
      0: begin q_x = 6'(body[0].x); q_y = 5'(body[0].y); end
      1: begin q_x = 6'(m_fx); q_y = 5'(m_fy); end
      2: begin
        k = $urandom_range(0, body.size() - 1);
        q_x = 6'(body[k].x); q_y = 5'(body[k].y);
      end
      default: begin q_x = 6'($urandom_range(0, 63)); q_y = 5'($urandom_range(0, 31)); end
    endcase
  endtask

  task automatic steer();
    int r, hx, hy;
    logic [3:0] d;
    d  = 4'b0000;
    r  = $urandom_range(0, 99);
    hx = body[0].x;
    hy = body[0].y;
    if (r < 20) begin
      if ($urandom_range(0, 1) == 1 && m_fy != hy) d = (m_fy < hy) ? 4'b0001 : 4'b0010;
      else if (m_fx > hx) d = 4'b1000;
      else if (m_fx < hx) d = 4'b0100;
      else if (m_fy < hy) d = 4'b0001;
      else if (m_fy > hy) d = 4'b0010;
    end else if (r < 25) begin
      d = 4'($urandom_range(0, 15));
    end
    direct_x = d;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rand_q) pick_query();
    end
  endtask

  task automatic pulse_sta();
    sta_en = 1'b1; cyc(2);
    sta_en = 1'b0; cyc(2);
  endtask

  initial begin
    bit did_reset;
    direct_x = '0; sta_en = 1'b0; q_x = '0; q_y = '0;
    did_reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("power_on_reset");
    rst_n = 1'b1;

    // Idle board queries: head, food, out-of-grid, body
    q_x = 6'd20; q_y = 5'd15; cyc(1);
    q_x = 6'd30; q_y = 5'd15; cyc(1);
    q_x = 6'd63; q_y = 5'd31; cyc(1);
    q_x = 6'd19; q_y = 5'd15; cyc(1);
    rand_q = 1'b1;
    cyc(8);

    // Straight run right: eats the initial food, then hits the right wall
    pulse_sta();
    cyc(110);

    // Restart; a reverse request is ignored, then turn up into the top wall
    pulse_sta();
    pulse_sta();
    direct_x = 4'b0100; cyc(1);
    direct_x = 4'b0000; cyc(6);
    direct_x = 4'b0001; cyc(1);
    direct_x = 4'b0000; cyc(90);

    // Random play with food seeking, restarts and one asynchronous reset mid-run
    for (int c = 0; c < 24000; c++) begin
      steer();
      if (m_st == 0 || m_st == 3) begin
        if ($urandom_range(0, 5) == 0) sta_en = ~sta_en;
      end else if ($urandom_range(0, 49) == 0) begin
        sta_en = ~sta_en;
      end
      if (!did_reset && c >= 12000 && m_st == 1) begin
        did_reset = 1'b1;
        q_x = 6'(body[0].x); q_y = 5'(body[0].y);
        cyc(1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrun_reset");
        cyc(2);
        rst_n = 1'b1;
      end
      cyc(1);
    end
    direct_x = '0;
    cyc(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
